// File: rtl/data_ram_arbiter_pkg.sv
// rtl/data_ram_arbiter_pkg.sv - shared ids and defaults for the data RAM arbiter
package data_ram_arbiter_pkg;
  localparam logic ARB_ID_PIPE          = 1'b0;
  localparam logic ARB_ID_AUX           = 1'b1;
  localparam int   STARVE_LIMIT_DEFAULT = 4;
  localparam int   STARVE_CNT_W         = 4;
endpackage

// File: rtl/data_ram_arbiter_starve.sv
// rtl/data_ram_arbiter_starve.sv - saturating denial counter that forces an aux grant
module arb_starve_counter
  import data_ram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic m1_req,
  input  logic m1_gnt,
  output logic force_gnt
);
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Any cycle without an outstanding aux request restarts the count.
  always_comb begin
    starve_cnt_d = '0;
    if (m1_req && !m1_gnt) begin
      starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end

  assign force_gnt = m1_req & (starve_cnt_q == LIMIT);
endmodule

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - single-port data RAM shared by pipeline (m0) and aux loader (m1)
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [DATA_W/8-1:0] m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic [DATA_W/8-1:0] m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);
  logic force_gnt;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;

  arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk       (clk),
    .reset     (reset),
    .m1_req    (m1_req),
    .m1_gnt    (m1_gnt),
    .force_gnt (force_gnt)
  );

  // Grants are held off during reset so nothing reaches the RAM or the read tracker.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (force_gnt)   m1_gnt = 1'b1;
      else if (m0_req) m0_gnt = 1'b1;
      else if (m1_req) m1_gnt = 1'b1;
    end
  end

  always_comb begin
    ram_en    = m0_gnt | m1_gnt;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (m0_gnt) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else if (m1_gnt) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
  end

  always_comb begin
    rd_pend_d  = ram_en & (ram_we == '0);
    rd_owner_d = rd_owner_q;
    if (rd_pend_d) rd_owner_d = m1_gnt ? ARB_ID_AUX : ARB_ID_PIPE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= ARB_ID_PIPE;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign m0_rvalid = rd_pend_q & ~reset & (rd_owner_q == ARB_ID_PIPE);
  assign m1_rvalid = rd_pend_q & ~reset & (rd_owner_q == ARB_ID_AUX);
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;
endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - directed scoreboard bench for data_ram_arbiter
module tb_data_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata;

  typedef struct {
    bit          valid;
    bit          owner;
    logic [31:0] data;
  } rsp_t;

  rsp_t        scb[$];
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  data_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Synchronous-read byte-writable RAM driven by the arbiter.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr[11:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      if (ram_we == 4'b0) ram_rdata <= mem[ram_addr[11:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare against the bench's expected grants, then record the expected response.
  task automatic cycle(input bit eg0, input bit eg1);
    rsp_t        e, n;
    logic [3:0]  xwe;
    logic [31:0] xaddr, xwdata;
    @(negedge clk);
    e = scb.pop_front();
    if (reset) e.valid = 1'b0;
    xwe    = eg0 ? m0_we    : eg1 ? m1_we    : 4'b0;
    xaddr  = eg0 ? m0_addr  : eg1 ? m1_addr  : 32'b0;
    xwdata = eg0 ? m0_wdata : eg1 ? m1_wdata : 32'b0;
    check("m0_gnt",    32'(m0_gnt),    32'(eg0));
    check("m1_gnt",    32'(m1_gnt),    32'(eg1));
    check("ram_en",    32'(ram_en),    32'(eg0 | eg1));
    check("ram_we",    32'(ram_we),    32'(xwe));
    check("ram_addr",  ram_addr,       xaddr);
    check("ram_wdata", ram_wdata,      xwdata);
    check("m0_rvalid", 32'(m0_rvalid), 32'(e.valid & !e.owner));
    check("m1_rvalid", 32'(m1_rvalid), 32'(e.valid & e.owner));
    if (e.valid && !e.owner) check("m0_rdata", m0_rdata, e.data);
    if (e.valid &&  e.owner) check("m1_rdata", m1_rdata, e.data);
    n.valid = (eg0 | eg1) && (xwe == 4'b0);
    n.owner = eg1;
    n.data  = ref_mem[xaddr[11:2]];
    scb.push_back(n);
    if (eg0 | eg1)
      for (int b = 0; b < 4; b++)
        if (xwe[b]) ref_mem[xaddr[11:2]][b*8 +: 8] = xwdata[b*8 +: 8];
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input bit req, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic drive1(input bit req, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
  endtask

  initial begin
    rsp_t idle;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hA500_0000 ^ (i * 32'h0001_0003);
      ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0003);
    end
    mem[32'h100 >> 2]     = 32'hDEAD_BEEF;
    ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    ram_rdata = '0;
    idle.valid = 1'b0; idle.owner = 1'b0; idle.data = '0;
    scb.push_back(idle);

    // Reset with an m0 read pending: nothing granted, nothing returned.
    reset = 1'b1;
    drive0(1'b1, 4'b0, 32'h100, 32'h0);
    drive1(1'b0, 4'b0, 32'h0, 32'h0);
    #1;
    cycle(0, 0);
    cycle(0, 0);
    reset = 1'b0;
    drive0(1'b0, 4'b0, 32'h0, 32'h0);
    cycle(0, 0);

    // m0 read alone.
    drive0(1'b1, 4'b0, 32'h100, 32'h0);
    cycle(1, 0);
    drive0(1'b0, 4'b0, 32'h0, 32'h0);
    cycle(0, 0);

    // m1 partial write, then read it back.
    drive1(1'b1, 4'b0010, 32'h204, 32'h0000_AB00);
    cycle(0, 1);
    drive1(1'b0, 4'b0, 32'h0, 32'h0);
    cycle(0, 0);
    drive1(1'b1, 4'b0, 32'h204, 32'h0);
    cycle(0, 1);
    drive1(1'b0, 4'b0, 32'h0, 32'h0);
    cycle(0, 0);

    // Both requesting continuously: four m0 grants, then a forced m1 grant.
    drive0(1'b1, 4'b0, 32'h40, 32'h0);
    drive1(1'b1, 4'b0, 32'h80, 32'h0);
    for (int i = 0; i < 10; i++) cycle((i % 5) != 4, (i % 5) == 4);
    drive0(1'b0, 4'b0, 32'h0, 32'h0);
    drive1(1'b0, 4'b0, 32'h0, 32'h0);
    cycle(0, 0);

    // Alternating single grants back to back.
    drive0(1'b1, 4'b0, 32'h10, 32'h0);
    cycle(1, 0);
    drive0(1'b0, 4'b0, 32'h0, 32'h0);
    drive1(1'b1, 4'b0, 32'h20, 32'h0);
    cycle(0, 1);
    drive1(1'b0, 4'b0, 32'h0, 32'h0);
    cycle(0, 0);
    cycle(0, 0);

    // m1 drops after three denials: the count restarts from zero.
    drive0(1'b1, 4'b0, 32'h30, 32'h0);
    drive1(1'b1, 4'b0, 32'h34, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1, 0);
    drive1(1'b0, 4'b0, 32'h0, 32'h0);
    cycle(1, 0);
    drive1(1'b1, 4'b0, 32'h34, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1, 0);
    cycle(0, 1);
    drive0(1'b0, 4'b0, 32'h0, 32'h0);
    drive1(1'b0, 4'b0, 32'h0, 32'h0);
    cycle(0, 0);
    cycle(0, 0);

    // Reset the cycle after an m0 read grant: the response is dropped.
    drive0(1'b1, 4'b0, 32'h100, 32'h0);
    cycle(1, 0);
    reset = 1'b1;
    cycle(0, 0);
    reset = 1'b0;
    drive0(1'b0, 4'b0, 32'h0, 32'h0);
    cycle(0, 0);
    drive0(1'b1, 4'b0, 32'h204, 32'h0);
    cycle(1, 0);
    drive0(1'b0, 4'b0, 32'h0, 32'h0);
    cycle(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
